// File: rtl/alu_seq_muldiv.sv
// Valid/ready ALU: 8 single-cycle ops plus bit-serial unsigned MUL/MULHU/DIVU/REMU.
// Latency 1 (single-cycle) / WIDTH+1 (iterative); result held in DONE until out_ready, in_ready only in IDLE.
module alu_seq_muldiv #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     mul_sum, div_trial;
    logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo;
    logic               div_ok;

    function automatic logic [WIDTH-1:0] alu_comb(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [SHAMT_W-1:0] sh;
        sh = b[SHAMT_W-1:0];
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1100: return a << sh;
            4'b1101: return a >> sh;
            4'b1110: return $signed(a) >>> sh;
            default: return '0;
        endcase
    endfunction

    // hi/lo form the shared 2*WIDTH register: {acc, multiplier} for mul, {rem, dividend/quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
        div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
        div_ok    = ~div_trial[WIDTH];
        div_hi    = div_ok ? div_trial[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        div_lo    = {lo_q[WIDTH-2:0], div_ok};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (alu_op[3:2] == 2'b10) begin
                        op_d    = alu_op[1:0];
                        hi_d    = '0;
                        lo_d    = alu_op[1] ? op1 : op2;
                        opnd_d  = alu_op[1] ? op2 : op1;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        result_d = alu_comb(alu_op, op1, op2);
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                hi_d  = op_q[1] ? div_hi : mul_hi;
                lo_d  = op_q[1] ? div_lo : mul_lo;
                cnt_d = cnt_q + SHAMT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    case (op_q)
                        2'b00:   result_d = mul_lo;
                        2'b01:   result_d = mul_hi;
                        2'b10:   result_d = div_lo;
                        default: result_d = div_hi;
                    endcase
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        zero_d      = (result_d == '0);
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_alu_seq_muldiv.sv
module tb_alu_seq_muldiv;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [3:0]   alu_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    always #5 clk = ~clk;

    alu_seq_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        z;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] OPS [12] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC,
                                        4'hD, 4'hE, 4'h8, 4'h9, 4'hA, 4'hB};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_iter(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    // Reference behaviour built from wide native arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'b0, a} * {64'b0, b};
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h7: return (a < b) ? 64'd1 : 64'd0;
            4'hC: return a << b[5:0];
            4'hD: return a >> b[5:0];
            4'hE: return $signed(a) >>> b[5:0];
            4'h8: return p[63:0];
            4'h9: return p[127:64];
            4'hA: return (b == 0) ? '1 : a / b;
            4'hB: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input string name);
        exp_t e;
        int   n;
        wait_idle(name);
        in_valid = 1'b1;
        alu_op   = op;
        op1      = a;
        op2      = b;
        e.res = exp;
        e.z   = (exp == 64'd0);
        e.lat = is_iter(op) ? 65 : 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // keep a conflicting request up and scramble operands while the op is in flight
        alu_op = 4'h2;
        op1    = {$urandom, $urandom};
        op2    = {$urandom, $urandom};
        n = 1;
        @(negedge clk);
        chk({name, "_busy"}, {63'b0, busy}, {63'b0, is_iter(op)});
        chk({name, "_in_ready_low"}, {63'b0, in_ready}, 64'd0);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
            op1 = {$urandom, $urandom};
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        chk({name, "_latency"}, 64'(n), 64'(e.lat));
        chk({name, "_result"}, result, e.res);
        chk({name, "_zero"}, {63'b0, zero}, {63'b0, e.z});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [3:0]  rop;
        logic [63:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", {63'b0, zero}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0});
        vecs.push_back('{4'hE, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000});
        vecs.push_back('{4'h9, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{4'hA, 64'd100, 64'd7, 64'd14});
        vecs.push_back('{4'hB, 64'd100, 64'd7, 64'd2});
        vecs.push_back('{4'hA, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{4'hB, 64'd5, 64'd0, 64'd5});
        vecs.push_back('{4'h0, 64'hF0F0, 64'hFF00, 64'hF000});
        vecs.push_back('{4'h1, 64'hF0F0, 64'h0F0F, 64'hFFFF});
        vecs.push_back('{4'h6, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{4'h7, 64'd1, 64'd2, 64'd1});
        vecs.push_back('{4'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0});
        vecs.push_back('{4'hC, 64'd1, 64'h40, 64'd1});
        vecs.push_back('{4'hC, 64'd1, 64'd63, 64'h8000_0000_0000_0000});
        vecs.push_back('{4'hD, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000});
        vecs.push_back('{4'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1});
        vecs.push_back('{4'h8, 64'd3, 64'd5, 64'd15});
        vecs.push_back('{4'h8, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0});
        vecs.push_back('{4'h9, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1});
        vecs.push_back('{4'h3, 64'hFF, 64'hFF, 64'd0});

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            rop = OPS[$urandom_range(0, 11)];
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rnd%0d_op%h", i, rop));
        end

        // Backpressure: DIVU result must hold while out_ready is low and new requests are refused.
        wait_idle("bp");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 4'hA;
        op1       = 64'd100;
        op2       = 64'd7;
        @(posedge clk);
        #1;
        alu_op = 4'h2;
        op1    = 64'd1;
        op2    = 64'd1;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("bp_latency", 64'(cnt), 64'd65);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_result%0d", i), result, 64'd14);
            chk($sformatf("bp_hold_valid%0d", i), {63'b0, out_valid}, 64'd1);
            chk($sformatf("bp_hold_in_ready%0d", i), {63'b0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_valid", {63'b0, out_valid}, 64'd0);
        chk("bp_drain_in_ready", {63'b0, in_ready}, 64'd1);

        // Reset in the middle of a multiply.
        wait_idle("rstb");
        in_valid = 1'b1;
        alu_op   = 4'h8;
        op1      = 64'd7;
        op2      = 64'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstb_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rstb_result", result, 64'd0);
        chk("rstb_zero", {63'b0, zero}, 64'd1);
        chk("rstb_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstb_in_ready", {63'b0, in_ready}, 64'd1);
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rstb_no_result", 64'(cnt), 64'd0);

        // Reset while a result is parked in DONE.
        wait_idle("rstd");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 4'h1;
        op1       = 64'h5;
        op2       = 64'hA;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstd_pre_result", result, 64'hF);
        rst_n = 1'b0;
        #1;
        chk("rstd_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rstd_result", result, 64'd0);
        chk("rstd_zero", {63'b0, zero}, 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rstd_in_ready", {63'b0, in_ready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
